// File: rtl/logic_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_reset_pkg
// Summary  : Shared constants for the reset-synchronizer family.
// Revision : 1.0 - initial release
// ============================================================================
package logic_reset_pkg;

    localparam int RESET_SYNC_STAGES_MIN     = 2;
    localparam int RESET_SYNC_STAGES_DEFAULT = 2;

endpackage : logic_reset_pkg
`default_nettype wire

// File: rtl/logic_reset_shift_chain.sv
`default_nettype none
// ============================================================================
// Module   : logic_reset_shift_chain
// Summary  : Flop chain that shifts in a constant 1 and clears synchronously.
// Revision : 1.0 - initial release
// ============================================================================
module logic_reset_shift_chain
    import logic_reset_pkg::*;
#(
    parameter int STAGES = RESET_SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic [STAGES-1:0] chain
);

    logic [STAGES-1:0] r_chain;

    // Shift by expression rather than slicing so the chain also elaborates
    // cleanly for a single stage, letting the parent report the real error.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_chain <= '0;
        end else begin
            r_chain <= (r_chain << 1) | STAGES'(1);
        end
    end

    assign chain = r_chain;

endmodule : logic_reset_shift_chain
`default_nettype wire

// File: rtl/reset_synchronizer_unit.sv
`default_nettype none
// ============================================================================
// Module   : reset_synchronizer_unit
// Summary  : Aligns de-assertion of an active-low reset request to aclk.
//            Option macro: LOGIC_RESET_SYNCHRONIZER_ASYNC_ASSERT_EN
//            (output also gated directly by areset_n for immediate assertion).
// Revision : 1.0 - initial release
// ============================================================================
module reset_synchronizer_unit
    import logic_reset_pkg::*;
#(
    parameter int STAGES = RESET_SYNC_STAGES_DEFAULT
) (
    input  logic aclk,
    input  logic srst,
    input  logic areset_n,
    output logic areset_n_synced
);

    logic [STAGES-1:0] w_chain;

    if (STAGES < RESET_SYNC_STAGES_MIN) begin : g_stages_drc
        $fatal(1, "reset_synchronizer_unit: parameter STAGES=%0d must be >= %0d",
               STAGES, RESET_SYNC_STAGES_MIN);
    end

    // A low request is sampled as data: it clears the whole chain at once.
    logic_reset_shift_chain #(
        .STAGES (STAGES)
    ) u_chain (
        .clk   (aclk),
        .rst   (srst),
        .clear (~areset_n),
        .chain (w_chain)
    );

`ifdef LOGIC_RESET_SYNCHRONIZER_ASYNC_ASSERT_EN
    assign areset_n_synced = w_chain[STAGES-1] & areset_n;
`else
    assign areset_n_synced = w_chain[STAGES-1];
`endif

endmodule : reset_synchronizer_unit
`default_nettype wire

// File: tb/tb_reset_synchronizer_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_synchronizer_unit
// Summary  : Scoreboard bench driving STAGES=2/3/4 instances in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_synchronizer_unit;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       areset_n = 1'b1;
    logic [2:0] synced;   // {S4, S3, S2}

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         row;
        logic [2:0] exp;
    } item_t;

    item_t sb_q[$];

    always #5 clk = ~clk;

    reset_synchronizer_unit #(.STAGES(2)) u_s2 (
        .aclk(clk), .srst(srst), .areset_n(areset_n), .areset_n_synced(synced[0]));
    reset_synchronizer_unit #(.STAGES(3)) u_s3 (
        .aclk(clk), .srst(srst), .areset_n(areset_n), .areset_n_synced(synced[1]));
    reset_synchronizer_unit #(.STAGES(4)) u_s4 (
        .aclk(clk), .srst(srst), .areset_n(areset_n), .areset_n_synced(synced[2]));

    task automatic check_bit(input string name, input int row, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, req);
        end
    endtask

    // Monitor: one post-edge sample per queued entry.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            item_t it;
            it = sb_q.pop_front();
            check_bit("s2", it.row, synced[0], it.exp[0]);
            check_bit("s3", it.row, synced[1], it.exp[1]);
            check_bit("s4", it.row, synced[2], it.exp[2]);
        end
    end

    int row_idx = 0;

    task automatic step(input logic s, input logic a, input logic [2:0] e);
        item_t it;
        @(negedge clk);
        srst     = s;
        areset_n = a;
        row_idx++;
        it.row = row_idx;
        it.exp = e;
        sb_q.push_back(it);
    endtask

`ifdef LOGIC_RESET_SYNCHRONIZER_ASYNC_ASSERT_EN
    localparam logic [2:0] PULSE_EXP = 3'b000;
`else
    localparam logic [2:0] PULSE_EXP = 3'b111;
`endif

    initial begin
        // srst with areset_n high, then release: S2/S3/S4 rise after 2/3/4 edges
        step(1, 1, 3'b000);
        step(1, 1, 3'b000);
        step(0, 1, 3'b000);
        step(0, 1, 3'b001);
        step(0, 1, 3'b011);
        step(0, 1, 3'b111);
        // request held low 3 cycles
        step(0, 0, 3'b000);
        step(0, 0, 3'b000);
        step(0, 0, 3'b000);
        // one high sample, interrupted, then full restart
        step(0, 1, 3'b000);
        step(0, 0, 3'b000);
        step(0, 1, 3'b000);
        step(0, 1, 3'b001);
        step(0, 1, 3'b011);
        step(0, 1, 3'b111);
        // srst wins over a high request; srst together with low request
        step(1, 1, 3'b000);
        step(1, 0, 3'b000);
        step(0, 1, 3'b000);
        step(0, 1, 3'b001);
        step(0, 1, 3'b011);
        step(0, 1, 3'b111);
        step(0, 1, 3'b111);

        // Sub-period low pulse entirely between edges
        @(posedge clk);
        #2;
        areset_n = 1'b0;
        #1;
        check_bit("pulse_s2", 0, synced[0], PULSE_EXP[0]);
        check_bit("pulse_s3", 0, synced[1], PULSE_EXP[1]);
        check_bit("pulse_s4", 0, synced[2], PULSE_EXP[2]);
        areset_n = 1'b1;
        #1;
        check_bit("after_pulse", 0, synced[2], 1'b1);
        step(0, 1, 3'b111);

        // Mid-cycle fall of the request, then sampled low
        step(0, 0, 3'b000);
        #1;
        check_bit("fall_s2", 0, synced[0], PULSE_EXP[0]);
        check_bit("fall_s4", 0, synced[2], PULSE_EXP[2]);
        step(0, 1, 3'b000);
        step(0, 1, 3'b001);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        if (sb_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_reset_synchronizer_unit
`default_nettype wire
